// File: rtl/dip_debouncer.sv
// dip_debouncer: synchronizes, debounces and edge-detects the board DIP
// switches. Each channel needs DEBOUNCE_CYCLES consecutive disagreeing
// samples before its clean level flips.
// Optional feature macro: DIP_DEBOUNCER_EVENT_EN builds the change-event
// latch with its valid/ack handshake. Without it, EVT_* outputs are tied low.
module dip_debouncer #(
  parameter int unsigned N_DIP           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_DIP-1:0] DIP,
  output logic [N_DIP-1:0] DIP_CLEAN,
  output logic [N_DIP-1:0] DIP_RISE,
  output logic [N_DIP-1:0] DIP_FALL,
  output logic             EVT_VALID,
  output logic [N_DIP-1:0] EVT_DATA,
  output logic             EVT_OVF,
  input  logic             EVT_ACK
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_DIP-1:0] s1;
  logic [N_DIP-1:0] s2;
  logic [N_DIP-1:0] upd;
  logic [N_DIP-1:0] clean_nxt;
  logic [CW-1:0]    cnt [N_DIP];

  // Two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= DIP;
      s2 <= s1;
    end
  end

  // A channel flips when it still disagrees on the last counted cycle.
  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < N_DIP; i++) begin
      upd[i] = (s2[i] != DIP_CLEAN[i]) && (cnt[i] == CNT_LAST);
    end
    clean_nxt = DIP_CLEAN ^ upd;
  end

  // Per-channel stability counters; any agreement or an accepted flip restarts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < N_DIP; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_DIP; i++) begin
        if ((s2[i] == DIP_CLEAN[i]) || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clean levels and registered one-cycle edge pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DIP_CLEAN <= '0;
      DIP_RISE  <= '0;
      DIP_FALL  <= '0;
    end else begin
      DIP_CLEAN <= clean_nxt;
      DIP_RISE  <= upd & s2;
      DIP_FALL  <= upd & ~s2;
    end
  end

`ifdef DIP_DEBOUNCER_EVENT_EN
  logic chg;

  assign chg = |upd;

  // Event latch: the change is taken from the same-edge update vector so the
  // event lands together with DIP_CLEAN rather than one cycle behind it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      EVT_VALID <= 1'b0;
      EVT_DATA  <= '0;
      EVT_OVF   <= 1'b0;
    end else if (chg) begin
      EVT_VALID <= 1'b1;
      EVT_DATA  <= clean_nxt;
      if (EVT_VALID) begin
        EVT_OVF <= ~EVT_ACK;
      end
    end else if (EVT_VALID && EVT_ACK) begin
      EVT_VALID <= 1'b0;
      EVT_OVF   <= 1'b0;
    end
  end
`else
  logic unused_ack;

  assign unused_ack = EVT_ACK;
  assign EVT_VALID  = 1'b0;
  assign EVT_DATA   = '0;
  assign EVT_OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_dip_debouncer.sv
// Testbench for dip_debouncer: directed scenarios plus randomized pin
// activity, checked each cycle against a sample-history reference model.
module tb_dip_debouncer;

  localparam int N = 2;
  localparam int D = 4;

  logic         CLK;
  logic         RST_N;
  logic [N-1:0] DIP;
  logic [N-1:0] DIP_CLEAN;
  logic [N-1:0] DIP_RISE;
  logic [N-1:0] DIP_FALL;
  logic         EVT_VALID;
  logic [N-1:0] EVT_DATA;
  logic         EVT_OVF;
  logic         EVT_ACK;

  int n_checks = 0;
  int n_errors = 0;

  dip_debouncer #(.N_DIP(N), .DEBOUNCE_CYCLES(D)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DIP       (DIP),
    .DIP_CLEAN (DIP_CLEAN),
    .DIP_RISE  (DIP_RISE),
    .DIP_FALL  (DIP_FALL),
    .EVT_VALID (EVT_VALID),
    .EVT_DATA  (EVT_DATA),
    .EVT_OVF   (EVT_OVF),
    .EVT_ACK   (EVT_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  logic [N-1:0] m_s1, m_s2, m_clean, m_rise, m_fall, m_data;
  logic         m_valid, m_ovf;
  logic [N-1:0] hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
    m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
    hist.delete();
  endtask

  // One clock of the model: a level is accepted once the last D synchronized
  // samples all disagree with the current clean level.
  task automatic model_step();
    logic [N-1:0] nclean;
    bit all;
    hist.push_back(m_s2);
    if (hist.size() > D) void'(hist.pop_front());
    nclean = m_clean;
    for (int i = 0; i < N; i++) begin
      if (hist.size() == D) begin
        all = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_clean[i]) all = 1'b0;
        if (all) nclean[i] = ~m_clean[i];
      end
    end
    m_rise = nclean & ~m_clean;
    m_fall = ~nclean & m_clean;
`ifdef DIP_DEBOUNCER_EVENT_EN
    if (nclean != m_clean) begin
      if (m_valid) m_ovf = !EVT_ACK;
      m_valid = 1'b1;
      m_data  = nclean;
    end else if (m_valid && EVT_ACK) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
`endif
    m_s2 = m_s1;
    m_s1 = DIP;
    m_clean = nclean;
  endtask

  task automatic compare_all();
    check("clean", 32'(DIP_CLEAN), 32'(m_clean));
    check("rise",  32'(DIP_RISE),  32'(m_rise));
    check("fall",  32'(DIP_FALL),  32'(m_fall));
    check("valid", 32'(EVT_VALID), 32'(m_valid));
    check("data",  32'(EVT_DATA),  32'(m_data));
    check("ovf",   32'(EVT_OVF),   32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST_N) model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ack_pulse();
    EVT_ACK = 1'b1;
    tick();
    EVT_ACK = 1'b0;
    tick();
  endtask

  int  hold [N];
  bit  seen;

  initial begin
    // Reset with switches held high
    RST_N = 1'b0; DIP = 2'b11; EVT_ACK = 1'b0;
    model_reset();
    #1;
    check("rst_clean", 32'(DIP_CLEAN), 32'd0);
    check("rst_rise",  32'(DIP_RISE),  32'd0);
    check("rst_valid", 32'(EVT_VALID), 32'd0);
    ticks(3);
    RST_N = 1'b1;
    ticks(5);
    check("rel_clean_early", 32'(DIP_CLEAN), 32'd0);
    tick();
    check("rel_clean", 32'(DIP_CLEAN), 32'd3);
    check("rel_rise",  32'(DIP_RISE),  32'd3);
`ifdef DIP_DEBOUNCER_EVENT_EN
    check("rel_valid", 32'(EVT_VALID), 32'd1);
    check("rel_data",  32'(EVT_DATA),  32'd3);
`endif
    tick();
    check("rel_rise_once", 32'(DIP_RISE), 32'd0);

    // Return to 00 and clear the event
    ack_pulse();
    DIP = 2'b00;
    ticks(8);
    ack_pulse();

    // Glitch rejection: 3-cycle pulse on bit 0
    seen = 1'b0;
    DIP = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (DIP_CLEAN != 0 || DIP_RISE != 0) seen = 1'b1;
    end
    DIP = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (DIP_CLEAN != 0 || DIP_RISE != 0) seen = 1'b1;
    end
    check("glitch_seen",  32'(seen),      32'd0);
    check("glitch_valid", 32'(EVT_VALID), 32'd0);

    // Clean transition on bit 1
    DIP = 2'b10;
    ticks(5);
    check("tr_clean_early", 32'(DIP_CLEAN), 32'd0);
    tick();
    check("tr_clean", 32'(DIP_CLEAN), 32'd2);
    check("tr_rise",  32'(DIP_RISE),  32'd2);
    check("tr_fall",  32'(DIP_FALL),  32'd0);
`ifdef DIP_DEBOUNCER_EVENT_EN
    check("tr_data",  32'(EVT_DATA),  32'd2);
`endif
    tick();
    check("tr_rise_once", 32'(DIP_RISE), 32'd0);

    // Overflow: second change on bit 0 without ack
    DIP = 2'b11;
    ticks(6);
`ifdef DIP_DEBOUNCER_EVENT_EN
    check("ovf_data",  32'(EVT_DATA), 32'd3);
    check("ovf_set",   32'(EVT_OVF),  32'd1);
`endif
    EVT_ACK = 1'b1;
    tick();
    EVT_ACK = 1'b0;
    check("ovf_ack_valid", 32'(EVT_VALID), 32'd0);
    check("ovf_ack_ovf",   32'(EVT_OVF),   32'd0);

    // Simultaneous ack and change while overflowed
    DIP = 2'b10;
    ticks(6);
    DIP = 2'b00;
    ticks(6);
`ifdef DIP_DEBOUNCER_EVENT_EN
    check("sim_pre_ovf", 32'(EVT_OVF), 32'd1);
`endif
    DIP = 2'b01;
    ticks(5);
    EVT_ACK = 1'b1;
    tick();
    EVT_ACK = 1'b0;
`ifdef DIP_DEBOUNCER_EVENT_EN
    check("sim_valid", 32'(EVT_VALID), 32'd1);
    check("sim_data",  32'(EVT_DATA),  32'd1);
`endif
    check("sim_ovf", 32'(EVT_OVF), 32'd0);

    // Mid-bounce reset
    ack_pulse();
    DIP = 2'b00;
    ticks(8);
    ack_pulse();
    DIP = 2'b01;
    ticks(3);
    check("mb_no_rise", 32'(DIP_RISE), 32'd0);
    RST_N = 1'b0;
    model_reset();
    #1;
    compare_all();
    ticks(2);
    RST_N = 1'b1;
    ticks(5);
    check("mb_rise_early", 32'(DIP_RISE), 32'd0);
    tick();
    check("mb_rise",  32'(DIP_RISE),  32'd1);
    check("mb_clean", 32'(DIP_CLEAN), 32'd1);

    // Randomized pin activity, acks and occasional resets
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          DIP[i]  = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 2 * D + 2));
        end else begin
          hold[i]--;
        end
      end
      EVT_ACK = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick();
        RST_N = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
